// File: rtl/mac_r_gmii_if.sv
// ============================================================================
// Module   : mac_r_gmii_if
// Purpose  : Ingress FIFO side of the receive MAC. Carries the byte-write
//            strobe/data toward the data FIFO, the status-word write toward
//            the pointer FIFO, the per-frame drop pulse, and the two
//            back-pressure inputs returned by the FIFOs.
// Modports : master - the receive MAC (drives writes, samples bp/full)
//            slave  - the ingress FIFOs (sample writes, drive bp/full)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mac_r_gmii_if;
    logic        bp;
    logic        ptr_fifo_full;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_dout;
    logic        ptr_fifo_wr;
    logic [15:0] ptr_fifo_dout;
    logic        frame_drop;

    modport master (
        input  bp, ptr_fifo_full,
        output data_fifo_wr, data_fifo_dout, ptr_fifo_wr, ptr_fifo_dout, frame_drop
    );

    modport slave (
        output bp, ptr_fifo_full,
        input  data_fifo_wr, data_fifo_dout, ptr_fifo_wr, ptr_fifo_dout, frame_drop
    );
endinterface

`default_nettype wire

// File: rtl/mac_r_gmii.sv
// ============================================================================
// Module   : mac_r_gmii
// Purpose  : Receive MAC. Accepts GMII bytes or MII nibbles, strips the
//            preamble/SFD, writes frame bytes (FCS included) to the ingress
//            data FIFO and one 16-bit status/length word per accepted frame
//            to the pointer FIFO.
// Ports    : clk, rstn        receive clock, async active-low reset
//            speed[1:0]       speed[1]=1 GMII byte mode, else MII nibbles
//            rx_dv/rx_er/rx_d PHY receive interface
//            fifo_if          ingress FIFO side (mac_r_gmii_if.master)
// Status   : [15] crc_err [14] len_err [13] rx_er seen [12] MII dribble
//            [11] 0 [10:0] length in bytes including FCS
// Config   : define MAC_R_CRC_CHECK_EN to build the FCS checker; otherwise
//            status bit 15 is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_r_gmii #(
    parameter int DELAY   = 2,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic [1:0]  speed,
    input  wire logic        rx_dv,
    input  wire logic        rx_er,
    input  wire logic [7:0]  rx_d,
    mac_r_gmii_if.master     fifo_if
);

    // DELAY only matters to harnesses that model clock-to-q; this body applies none.
    localparam int          c_unused_delay = DELAY;
    localparam logic [10:0] c_MIN_LEN = 11'(MIN_LEN);
    localparam logic [10:0] c_MAX_LEN = 11'(MAX_LEN);
    localparam logic [10:0] c_LEN_SAT = 11'h7FF;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PRE  = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_DROP = 3'd3;
    localparam logic [2:0] c_ST_STAT = 3'd4;

    // Only speed[1] distinguishes byte from nibble mode.
    wire w_unused_speed = speed[0];

    logic        r_dv, r_er;
    logic [7:0]  r_d;
    logic        r_phase;        // 1: a low nibble is held, waiting for its pair
    logic [3:0]  r_lo;
    logic [2:0]  r_state;
    logic        r_gmii;
    logic [10:0] r_len;
    logic        r_ovf, r_er_flag, r_dribble;
    logic        r_data_wr, r_ptr_wr, r_drop;
    logic [7:0]  r_data_dout;
    logic [15:0] r_ptr_dout;

    logic        w_gmii, w_bv, w_sfd_ok, w_byte_wr, w_crc_err, w_len_err;
    logic [7:0]  w_byte;
    logic [15:0] w_status;

    // Input stage and nibble assembler. Phase is forced to 0 whenever dv is
    // low, so every frame starts on a low nibble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dv    <= 1'b0;
            r_er    <= 1'b0;
            r_d     <= 8'h00;
            r_phase <= 1'b0;
            r_lo    <= 4'h0;
        end else begin
            r_dv <= rx_dv;
            r_er <= rx_er;
            r_d  <= rx_d;
            if (r_dv) begin
                r_phase <= ~r_phase;
                if (!r_phase) r_lo <= r_d[3:0];
            end else begin
                r_phase <= 1'b0;
            end
        end
    end

    // Mode follows the pin while idle and is frozen for the rest of the frame.
    assign w_gmii    = (r_state == c_ST_IDLE) ? speed[1] : r_gmii;
    assign w_bv      = r_dv & (w_gmii | r_phase);
    assign w_byte    = w_gmii ? r_d : {r_d[3:0], r_lo};
    assign w_sfd_ok  = (r_state == c_ST_PRE) & w_bv & (w_byte == 8'hD5)
                     & ~(fifo_if.bp | fifo_if.ptr_fifo_full);
    assign w_byte_wr = (r_state == c_ST_DATA) & w_bv & (r_len != c_LEN_SAT);

`ifdef MAC_R_CRC_CHECK_EN
    logic [31:0] r_crc;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c;
        for (int i = 0; i < 8; i++) begin
            v = (v >> 1) ^ ((v[0] ^ d[i]) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return v;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (w_sfd_ok) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (w_byte_wr) begin
            r_crc <= f_crc8(r_crc, w_byte);
        end
    end

    // Running the FCS through the register leaves this fixed residue.
    assign w_crc_err = (r_crc != 32'hDEBB20E3);
`else
    assign w_crc_err = 1'b0;
`endif

    assign w_len_err = r_ovf | (r_len < c_MIN_LEN) | (r_len > c_MAX_LEN);
    assign w_status  = {w_crc_err, w_len_err, r_er_flag, r_dribble, 1'b0, r_len};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_ST_IDLE;
            r_gmii      <= 1'b0;
            r_len       <= 11'd0;
            r_ovf       <= 1'b0;
            r_er_flag   <= 1'b0;
            r_dribble   <= 1'b0;
            r_data_wr   <= 1'b0;
            r_data_dout <= 8'h00;
            r_ptr_wr    <= 1'b0;
            r_ptr_dout  <= 16'h0000;
            r_drop      <= 1'b0;
        end else begin
            r_data_wr <= 1'b0;
            r_ptr_wr  <= 1'b0;
            r_drop    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_gmii <= speed[1];
                    if (w_bv) r_state <= (w_byte == 8'h55) ? c_ST_PRE : c_ST_DROP;
                end
                c_ST_PRE: begin
                    if (!r_dv) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_bv && w_byte != 8'h55) begin
                        if (w_sfd_ok) begin
                            r_len     <= 11'd0;
                            r_ovf     <= 1'b0;
                            r_er_flag <= 1'b0;
                            r_dribble <= 1'b0;
                            r_state   <= c_ST_DATA;
                        end else begin
                            // Only a blocked SFD counts as a dropped frame.
                            r_drop  <= (w_byte == 8'hD5);
                            r_state <= c_ST_DROP;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (r_er) r_er_flag <= 1'b1;
                    if (!r_dv) begin
                        r_dribble <= ~r_gmii & r_phase;
                        r_state   <= c_ST_STAT;
                    end else if (w_byte_wr) begin
                        r_data_wr   <= 1'b1;
                        r_data_dout <= w_byte;
                        r_len       <= r_len + 11'd1;
                    end else if (w_bv) begin
                        r_ovf <= 1'b1;
                    end
                end
                c_ST_STAT: begin
                    r_ptr_wr   <= 1'b1;
                    r_ptr_dout <= w_status;
                    r_state    <= c_ST_IDLE;
                end
                c_ST_DROP: begin
                    if (!r_dv) r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign fifo_if.data_fifo_wr   = r_data_wr;
    assign fifo_if.data_fifo_dout = r_data_dout;
    assign fifo_if.ptr_fifo_wr    = r_ptr_wr;
    assign fifo_if.ptr_fifo_dout  = r_ptr_dout;
    assign fifo_if.frame_drop     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_mac_r_gmii.sv
// ============================================================================
// Module   : tb_mac_r_gmii
// Purpose  : Self-checking bench for mac_r_gmii. Frames are built as byte
//            lists with a CRC-32 FCS, sent in GMII or MII form, and the
//            captured FIFO writes are compared to what the frame rules say
//            they must be.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mac_r_gmii;
    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic [1:0] speed = 2'b10;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic [7:0] rx_d  = 8'h00;

    mac_r_gmii_if u_if();

    mac_r_gmii #(.DELAY(2), .MAX_LEN(1518), .MIN_LEN(64)) u_dut (
        .clk    (clk),
        .rstn   (rstn),
        .speed  (speed),
        .rx_dv  (rx_dv),
        .rx_er  (rx_er),
        .rx_d   (rx_d),
        .fifo_if(u_if)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int drop_cnt = 0;

    logic [7:0]  tx_frame[$];
    logic [7:0]  exp_all[$];
    logic [7:0]  got_bytes[$];
    int          got_byte_cyc[$];
    logic [15:0] got_stat[$];
    int          got_stat_cyc[$];

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.data_fifo_wr) begin
            got_bytes.push_back(u_if.data_fifo_dout);
            got_byte_cyc.push_back(cyc);
        end
        if (u_if.ptr_fifo_wr) begin
            got_stat.push_back(u_if.ptr_fifo_dout);
            got_stat_cyc.push_back(cyc);
        end
        if (u_if.frame_drop) drop_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic logic [15:0] exp_status(input int n, input bit drib, input bit er);
        int len;
        bit crc_bad;
        len = (n > 2047) ? 2047 : n;
`ifdef MAC_R_CRC_CHECK_EN
        crc_bad = ({tx_frame[n-1], tx_frame[n-2], tx_frame[n-3], tx_frame[n-4]} != crc32_of(n - 4));
`else
        crc_bad = 1'b0;
`endif
        return {crc_bad, (n < 64 || n > 1518), er, drib, 1'b0, 11'(len)};
    endfunction

    function automatic int byte_diff();
        int nd = 0;
        for (int i = 0; i < got_bytes.size() && i < exp_all.size(); i++)
            if (got_bytes[i] !== exp_all[i]) nd++;
        return nd;
    endfunction

    function automatic logic [15:0] stat_at(input int i);
        return (i < got_stat.size()) ? got_stat[i] : 16'hDEAD;
    endfunction

    function automatic int stat_cyc_at(input int i);
        return (i < got_stat_cyc.size()) ? got_stat_cyc[i] : -1;
    endfunction

    function automatic int byte_cyc_at(input int i);
        return (i < got_byte_cyc.size()) ? got_byte_cyc[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    task automatic clear_mon();
        got_bytes.delete(); got_byte_cyc.delete();
        got_stat.delete();  got_stat_cyc.delete();
        exp_all.delete();
        drop_cnt = 0;
    endtask

    task automatic build_frame(input int n, input bit rnd, input bit bad);
        logic [31:0] fcs;
        tx_frame.delete();
        for (int i = 0; i < n - 4; i++) tx_frame.push_back(rnd ? 8'($urandom) : 8'(i));
        fcs = crc32_of(n - 4);
        for (int i = 0; i < 4; i++) tx_frame.push_back(fcs[8*i +: 8]);
        if (bad) tx_frame[n-1] = ~tx_frame[n-1];
        foreach (tx_frame[i]) exp_all.push_back(tx_frame[i]);
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic er, input logic mii, output int edge_hi);
        if (mii) begin
            @(negedge clk); rx_dv = 1'b1; rx_er = er; rx_d = {4'h0, b[3:0]};
            @(negedge clk); rx_er = er; rx_d = {4'h0, b[7:4]}; edge_hi = cyc + 1;
        end else begin
            @(negedge clk); rx_dv = 1'b1; rx_er = er; rx_d = b; edge_hi = cyc + 1;
        end
    endtask

    task automatic send_preamble(input logic mii);
        int eh;
        for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0, mii, eh);
        drive_byte(8'hD5, 1'b0, mii, eh);
    endtask

    task automatic send_frame(input logic mii, input int er_idx, input bit extra_nib,
                              input bit bp_mid, input int post_idle, output int de, output int le);
        int eh;
        de = -1;
        send_preamble(mii);
        for (int i = 0; i < tx_frame.size(); i++) begin
            drive_byte(tx_frame[i], (i == er_idx), mii, eh);
            if (i == 0) de = eh;
            if (bp_mid && i == 5) u_if.bp = 1'b1;
        end
        if (extra_nib) begin
            @(negedge clk); rx_er = 1'b0; rx_d = 8'h0A;
        end
        @(negedge clk); rx_dv = 1'b0; rx_er = 1'b0; rx_d = 8'h00; le = cyc + 1;
        if (bp_mid) u_if.bp = 1'b0;
        repeat (post_idle - 1) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_if.data_fifo_wr, u_if.ptr_fifo_wr, u_if.frame_drop} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000", {u_if.data_fifo_wr, u_if.ptr_fifo_wr, u_if.frame_drop});
        end
        checks++;
        if ({u_if.data_fifo_dout, u_if.ptr_fifo_dout} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=000000", {u_if.data_fifo_dout, u_if.ptr_fifo_dout});
        end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gmii_good();
        int de, le;
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 64) begin failures++; $display("FAIL gmii_count got=%0d exp=64", got_bytes.size()); end
        checks++;
        if (byte_diff() !== 0) begin failures++; $display("FAIL gmii_bytes got=%0d_diffs exp=0", byte_diff()); end
        checks++;
        if (got_stat.size() !== 1 || stat_at(0) !== 16'h0040) begin
            failures++; $display("FAIL gmii_status got=%h(n=%0d) exp=0040", stat_at(0), got_stat.size());
        end
        checks++;
        if (drop_cnt !== 0) begin failures++; $display("FAIL gmii_drop got=%0d exp=0", drop_cnt); end
        checks++;
        if (byte_cyc_at(0) !== de + 1) begin failures++; $display("FAIL gmii_data_latency got=%0d exp=%0d", byte_cyc_at(0), de + 1); end
        checks++;
        if (stat_cyc_at(0) !== le + 2) begin failures++; $display("FAIL gmii_ptr_latency got=%0d exp=%0d", stat_cyc_at(0), le + 2); end
    endtask

    task automatic test_gmii_bad_fcs();
        int de, le;
        logic [15:0] exp;
`ifdef MAC_R_CRC_CHECK_EN
        exp = 16'h8040;
`else
        exp = 16'h0040;
`endif
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b1);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_stat.size() !== 1 || stat_at(0) !== exp) begin
            failures++; $display("FAIL bad_fcs_status got=%h exp=%h", stat_at(0), exp);
        end
    endtask

    task automatic test_mii();
        int de, le;
        speed = 2'b01;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b1, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 64 || byte_diff() !== 0) begin
            failures++; $display("FAIL mii_bytes got=%0d/%0d_diffs exp=64/0", got_bytes.size(), byte_diff());
        end
        checks++;
        if (got_stat.size() !== 1 || stat_at(0) !== 16'h0040) begin
            failures++; $display("FAIL mii_status got=%h exp=0040", stat_at(0));
        end
        checks++;
        if (stat_cyc_at(0) !== le + 2) begin failures++; $display("FAIL mii_ptr_latency got=%0d exp=%0d", stat_cyc_at(0), le + 2); end
        checks++;
        begin
            int gap_bad = 0;
            for (int i = 1; i < got_byte_cyc.size(); i++) if (got_byte_cyc[i] - got_byte_cyc[i-1] < 2) gap_bad++;
            if (gap_bad !== 0) begin failures++; $display("FAIL mii_write_spacing got=%0d_close exp=0", gap_bad); end
        end
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b1, -1, 1'b1, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 64 || stat_at(0) !== 16'h1040) begin
            failures++; $display("FAIL mii_dribble got=%h/%0d exp=1040/64", stat_at(0), got_bytes.size());
        end
    endtask

    task automatic test_lengths();
        int de, le;
        speed = 2'b10;
        clear_mon(); build_frame(40, 1'b1, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 40 || stat_at(0) !== 16'h4028) begin
            failures++; $display("FAIL short_frame got=%h/%0d exp=4028/40", stat_at(0), got_bytes.size());
        end
        clear_mon(); build_frame(1600, 1'b1, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 1600 || byte_diff() !== 0 || stat_at(0) !== 16'h4640) begin
            failures++; $display("FAIL long_frame got=%h/%0d exp=4640/1600", stat_at(0), got_bytes.size());
        end
    endtask

    task automatic test_backpressure();
        int de, le;
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        u_if.bp = 1'b1;
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        u_if.bp = 1'b0;
        checks++;
        if (drop_cnt !== 1 || got_bytes.size() !== 0 || got_stat.size() !== 0) begin
            failures++; $display("FAIL bp_drop got=drop%0d/data%0d/ptr%0d exp=1/0/0", drop_cnt, got_bytes.size(), got_stat.size());
        end
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        u_if.ptr_fifo_full = 1'b1;
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        u_if.ptr_fifo_full = 1'b0;
        checks++;
        if (drop_cnt !== 1 || got_bytes.size() !== 0 || got_stat.size() !== 0) begin
            failures++; $display("FAIL full_drop got=drop%0d/data%0d/ptr%0d exp=1/0/0", drop_cnt, got_bytes.size(), got_stat.size());
        end
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b1, 8, de, le);
        checks++;
        if (drop_cnt !== 0 || got_bytes.size() !== 64 || stat_at(0) !== 16'h0040) begin
            failures++; $display("FAIL bp_after_sfd got=drop%0d/data%0d/%h exp=0/64/0040", drop_cnt, got_bytes.size(), stat_at(0));
        end
    endtask

    task automatic test_rx_er();
        int de, le;
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b0, 20, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (stat_at(0) !== 16'h2040) begin failures++; $display("FAIL rx_er_status got=%h exp=2040", stat_at(0)); end
    endtask

    task automatic test_pre_abort();
        int eh;
        speed = 2'b10;
        clear_mon();
        for (int i = 0; i < 4; i++) drive_byte(8'h55, 1'b0, 1'b0, eh);
        @(negedge clk); rx_dv = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (drop_cnt !== 0 || got_bytes.size() !== 0 || got_stat.size() !== 0) begin
            failures++; $display("FAIL pre_abort got=drop%0d/data%0d/ptr%0d exp=0/0/0", drop_cnt, got_bytes.size(), got_stat.size());
        end
    endtask

    task automatic test_reset_mid();
        int eh, de, le;
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_preamble(1'b0);
        for (int i = 0; i < 30; i++) drive_byte(tx_frame[i], 1'b0, 1'b0, eh);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({u_if.data_fifo_wr, u_if.ptr_fifo_wr, u_if.frame_drop, u_if.data_fifo_dout, u_if.ptr_fifo_dout} !== 27'h0) begin
            failures++; $display("FAIL reset_mid_outputs got=%h exp=0", {u_if.data_fifo_wr, u_if.data_fifo_dout, u_if.ptr_fifo_dout});
        end
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (got_stat.size() !== 0) begin failures++; $display("FAIL reset_mid_nostat got=%0d exp=0", got_stat.size()); end
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 64 || byte_diff() !== 0 || stat_at(0) !== 16'h0040) begin
            failures++; $display("FAIL reset_mid_next got=%h/%0d exp=0040/64", stat_at(0), got_bytes.size());
        end
    endtask

    task automatic test_back_to_back();
        int de, le, nb;
        logic [15:0] exp_b;
        speed = 2'b10;
        clear_mon(); build_frame(64, 1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 1, de, le);
        nb = $urandom_range(60, 120);
        build_frame(nb, 1'b1, 1'b0);
        exp_b = exp_status(nb, 1'b0, 1'b0);
        send_frame(1'b0, -1, 1'b0, 1'b0, 8, de, le);
        checks++;
        if (got_bytes.size() !== 64 + nb || byte_diff() !== 0) begin
            failures++; $display("FAIL b2b_bytes got=%0d/%0d_diffs exp=%0d/0", got_bytes.size(), byte_diff(), 64 + nb);
        end
        checks++;
        if (got_stat.size() !== 2 || stat_at(0) !== 16'h0040 || stat_at(1) !== exp_b) begin
            failures++; $display("FAIL b2b_status got=%h,%h exp=0040,%h", stat_at(0), stat_at(1), exp_b);
        end
    endtask

    task automatic test_random();
        int de, le, n, er;
        bit mii, bad, nib, bpm;
        logic [15:0] exp;
        for (int t = 0; t < 10; t++) begin
            speed = 2'($urandom_range(0, 3));
            mii   = ~speed[1];
            n     = $urandom_range(20, 300);
            bad   = ($urandom_range(0, 2) == 0);
            er    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            nib   = mii & ($urandom_range(0, 1) == 1);
            bpm   = ($urandom_range(0, 1) == 1);
            clear_mon(); build_frame(n, 1'b1, bad);
            exp = exp_status(n, nib, er >= 0);
            send_frame(mii, er, nib, bpm, 8, de, le);
            checks++;
            if (got_bytes.size() !== n || byte_diff() !== 0) begin
                failures++; $display("FAIL rand%0d_bytes got=%0d/%0d_diffs exp=%0d/0", t, got_bytes.size(), byte_diff(), n);
            end
            checks++;
            if (got_stat.size() !== 1 || stat_at(0) !== exp || drop_cnt !== 0) begin
                failures++; $display("FAIL rand%0d_status got=%h(n=%0d,drop=%0d) exp=%h", t, stat_at(0), got_stat.size(), drop_cnt, exp);
            end
        end
    endtask

    initial begin
        u_if.bp = 1'b0;
        u_if.ptr_fifo_full = 1'b0;
        test_reset();
        test_gmii_good();
        test_gmii_bad_fcs();
        test_mii();
        test_lengths();
        test_backpressure();
        test_rx_er();
        test_pre_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
